// File: rtl/adsr_envelope_if.sv
// Sample stream, gate and envelope controls between synth, ADSR and I2S2.
// Master drives the synth-side inputs; slave is the envelope block.
interface adsr_envelope_if #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int LEVEL_WIDTH  = 16
);
  logic                    gate_in;
  logic                    sample_valid_in;
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic [LEVEL_WIDTH-1:0]  attack_rate_in;
  logic [LEVEL_WIDTH-1:0]  decay_rate_in;
  logic [LEVEL_WIDTH-1:0]  sustain_level_in;
  logic [LEVEL_WIDTH-1:0]  release_rate_in;
  logic [SAMPLE_WIDTH-1:0] sample_out;
  logic                    valid_out;
  logic [LEVEL_WIDTH-1:0]  level_out;
  logic [2:0]              state_out;
  logic                    active_out;

  modport master (
    output gate_in, sample_valid_in, sample_in,
    output attack_rate_in, decay_rate_in,
    output sustain_level_in, release_rate_in,
    input  sample_out, valid_out, level_out,
    input  state_out, active_out
  );

  modport slave (
    input  gate_in, sample_valid_in, sample_in,
    input  attack_rate_in, decay_rate_in,
    input  sustain_level_in, release_rate_in,
    output sample_out, valid_out, level_out,
    output state_out, active_out
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with a 2-cycle sample scaling pipeline.
// Define ADSR_RETRIGGER_EN to restart ATTACK from 0 on every gate rising edge.
module adsr_envelope #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int LEVEL_WIDTH  = 16
) (
  input  logic clk_in,
  input  logic rst_n_in,
  adsr_envelope_if.slave bus
);

  localparam int LW = LEVEL_WIDTH;
  localparam int SW = SAMPLE_WIDTH;
  localparam int PW = SW + LW + 1;
  localparam logic [LW-1:0] LMAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   level, level_nx;
  logic            tick, gate, retrig;
  logic [LW:0]     atk_sum, dec_diff, rel_diff;
  logic signed [PW-1:0] prod, p;
  logic            v1;
  logic [SW-1:0]   sample_q;
  logic            valid_q;

  assign tick = bus.sample_valid_in;
  assign gate = bus.gate_in;

`ifdef ADSR_RETRIGGER_EN
  logic gate_q, rise, rise_pend;

  assign rise = gate & ~gate_q;

  // A press between ticks is held until the next tick consumes it
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gate_q    <= 1'b0;
      rise_pend <= 1'b0;
    end else begin
      gate_q <= gate;
      if (tick)
        rise_pend <= 1'b0;
      else if (rise)
        rise_pend <= 1'b1;
    end
  end

  assign retrig = rise | rise_pend;
`else
  assign retrig = 1'b0;
`endif

  assign atk_sum  = {1'b0, level} + {1'b0, bus.attack_rate_in};
  assign dec_diff = {1'b0, level} - {1'b0, bus.decay_rate_in};
  assign rel_diff = {1'b0, level} - {1'b0, bus.release_rate_in};

  always_comb begin
    state_nx = state;
    level_nx = level;
    if (tick) begin
      if (retrig && state != IDLE) begin
        state_nx = (bus.attack_rate_in == LMAX) ? DECAY : ATTACK;
        level_nx = bus.attack_rate_in;
      end else begin
        unique case (state)
          IDLE: begin
            if (gate) state_nx = ATTACK;
          end
          ATTACK: begin
            if (!gate) begin
              state_nx = RELEASE;
            end else if (atk_sum[LW] || atk_sum[LW-1:0] == LMAX) begin
              state_nx = DECAY;
              level_nx = LMAX;
            end else begin
              level_nx = atk_sum[LW-1:0];
            end
          end
          DECAY: begin
            // Also covers a sustain at or above the current level
            if (!gate) begin
              state_nx = RELEASE;
            end else if (dec_diff[LW] ||
                         dec_diff[LW-1:0] <= bus.sustain_level_in) begin
              state_nx = SUSTAIN;
              level_nx = bus.sustain_level_in;
            end else begin
              level_nx = dec_diff[LW-1:0];
            end
          end
          SUSTAIN: begin
            if (!gate) state_nx = RELEASE;
            else       level_nx = bus.sustain_level_in;
          end
          RELEASE: begin
            if (gate) begin
              state_nx = ATTACK;
            end else if (rel_diff[LW] || rel_diff[LW-1:0] == '0) begin
              state_nx = IDLE;
              level_nx = '0;
            end else begin
              level_nx = rel_diff[LW-1:0];
            end
          end
          default: begin
            state_nx = IDLE;
            level_nx = '0;
          end
        endcase
      end
    end
  end

  assign prod = PW'($signed(bus.sample_in)) * PW'($signed({1'b0, level}));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      level    <= '0;
      p        <= '0;
      v1       <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      level   <= level_nx;
      v1      <= tick;
      valid_q <= v1;
      if (tick) p <= prod;
      if (v1)   sample_q <= p[LW +: SW];
    end
  end

  assign bus.sample_out = sample_q;
  assign bus.valid_out  = valid_q;
  assign bus.level_out  = level;
  assign bus.state_out  = state;
  assign bus.active_out = (state != IDLE);

endmodule
